cpu_eu_pipe: RTL and testbench

CPU_EU_PIPE -- requirements
Module: cpu_eu_pipe

---
 rtl/cpu_eu_pkg.sv | 53 +++++
 rtl/cpu_eu_pipe_if.sv | 35 +++
 rtl/cpu_eu_alu.sv | 28 ++
 rtl/cpu_eu_pipe.sv | 133 +++++++++++++
 tb/tb_cpu_eu_pipe.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_eu_pkg.sv
// rtl/cpu_eu_pkg.sv - shared encodings, stage-2 state and ALU control decode for cpu_eu_pipe
package cpu_eu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [1:0] {
        S2_EMPTY = 2'd0,
        S2_WB    = 2'd1,
        S2_MEM   = 2'd2
    } s2_state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_NOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_ctrl_e;

    // Unknown funct codes fall back to add.
    function automatic alu_ctrl_e alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
        alu_ctrl_e ctrl;
        ctrl = ALU_ADD;
        case (aluop)
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_OR:  ctrl = ALU_OR;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_SUB: ctrl = ALU_SUB;
                    FUNCT_AND: ctrl = ALU_AND;
                    FUNCT_OR:  ctrl = ALU_OR;
                    FUNCT_NOR: ctrl = ALU_NOR;
                    FUNCT_SLT: ctrl = ALU_SLT;
                    default:   ctrl = ALU_ADD;
                endcase
            end
            default: ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/cpu_eu_pipe_if.sv
// rtl/cpu_eu_pipe_if.sv - instruction/control bundle, memory port and status of cpu_eu_pipe
interface cpu_eu_pipe_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic          RegDst;
    logic          ALUSrc;
    logic          RegWrite;
    logic          MemtoReg;
    logic          MemRead;
    logic          MemWrite;
    logic [1:0]    ALUOp;
    logic [25:0]   Instruction;
    logic          ram_req;
    logic          ram_we;
    logic [DW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          ram_ack;
    logic          zero;
    logic          busy;

    modport slave (
        input  in_valid, RegDst, ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite,
               ALUOp, Instruction, ram_rdata, ram_ack,
        output in_ready, ram_req, ram_we, ram_addr, ram_wdata, zero, busy
    );

    modport master (
        output in_valid, RegDst, ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite,
               ALUOp, Instruction, ram_rdata, ram_ack,
        input  in_ready, ram_req, ram_we, ram_addr, ram_wdata, zero, busy
    );
endinterface

// File: rtl/cpu_eu_alu.sv
// rtl/cpu_eu_alu.sv - combinational ALU with ALUOp/funct control decode
module cpu_eu_alu
    import cpu_eu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [1:0]    i_aluop,
    input  logic [5:0]    i_funct,
    output logic [DW-1:0] o_result
);
    alu_ctrl_e w_ctrl;

    assign w_ctrl = alu_decode(i_aluop, i_funct);

    always_comb begin
        o_result = i_a + i_b;
        case (w_ctrl)
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_NOR: o_result = ~(i_a | i_b);
            ALU_SLT: o_result = ($signed(i_a) < $signed(i_b)) ? DW'(1) : '0;
            default: o_result = i_a + i_b;
        endcase
    end
endmodule

// File: rtl/cpu_eu_pipe.sv
// rtl/cpu_eu_pipe.sv - two-stage execute / memory-writeback pipe with forwarding register file
module cpu_eu_pipe
    import cpu_eu_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    cpu_eu_pipe_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [DW-1:0] r_regs [NREG];
    s2_state_e     r_state;
    s2_state_e     w_next_state;
    logic [DW-1:0] r_alu;
    logic [DW-1:0] r_rtdata;
    logic [AW-1:0] r_dst;
    logic          r_regwrite;
    logic          r_memtoreg;
    logic          r_store;
    logic          r_zero;

    logic [AW-1:0] w_rs;
    logic [AW-1:0] w_rt;
    logic [AW-1:0] w_rd;
    logic [DW-1:0] w_rs_data;
    logic [DW-1:0] w_rt_data;
    logic [DW-1:0] w_imm;
    logic [DW-1:0] w_alu_b;
    logic [DW-1:0] w_alu_res;
    logic signed [15:0] w_imm16;
    logic          w_accept;
    logic          w_wr_en;
    logic [DW-1:0] w_wr_data;

    assign w_rs     = bus.Instruction[21 +: AW];
    assign w_rt     = bus.Instruction[16 +: AW];
    assign w_rd     = bus.Instruction[11 +: AW];
    assign w_imm16  = $signed(bus.Instruction[15:0]);
    assign w_imm    = DW'(w_imm16);
    assign w_accept = bus.in_valid && (r_state != S2_MEM);

    // Register 0 is hardwired; w_wr_en never targets it, so it is never forwarded either.
    assign w_rs_data = (w_rs == '0) ? '0 :
                       (w_wr_en && (r_dst == w_rs)) ? w_wr_data : r_regs[w_rs];
    assign w_rt_data = (w_rt == '0) ? '0 :
                       (w_wr_en && (r_dst == w_rt)) ? w_wr_data : r_regs[w_rt];
    assign w_alu_b   = bus.ALUSrc ? w_imm : w_rt_data;

    cpu_eu_alu #(.DW(DW)) u_alu (
        .i_a      (w_rs_data),
        .i_b      (w_alu_b),
        .i_aluop  (bus.ALUOp),
        .i_funct  (bus.Instruction[5:0]),
        .o_result (w_alu_res)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S2_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S2_EMPTY;
        if (w_accept) begin
            if (bus.MemRead || bus.MemWrite) begin
                w_next_state = S2_MEM;
            end else if (bus.RegWrite) begin
                w_next_state = S2_WB;
            end
        end else if ((r_state == S2_MEM) && !bus.ram_ack) begin
            w_next_state = S2_MEM;
        end
    end

    always_comb begin
        bus.in_ready = (r_state != S2_MEM);
        bus.busy     = (r_state != S2_EMPTY);
        bus.ram_req  = (r_state == S2_MEM);
        bus.ram_we   = (r_state == S2_MEM) && r_store;
        w_wr_en      = 1'b0;
        w_wr_data    = r_alu;
        case (r_state)
            S2_WB: w_wr_en = r_regwrite && (r_dst != '0);
            S2_MEM: begin
                w_wr_en = bus.ram_ack && !r_store && r_regwrite && (r_dst != '0);
                if (r_memtoreg) begin
                    w_wr_data = bus.ram_rdata;
                end
            end
            default: w_wr_en = 1'b0;
        endcase
    end

    assign bus.ram_addr  = r_alu;
    assign bus.ram_wdata = r_rtdata;
    assign bus.zero      = r_zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alu      <= '0;
            r_rtdata   <= '0;
            r_dst      <= '0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_store    <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_accept) begin
            r_alu      <= w_alu_res;
            r_rtdata   <= w_rt_data;
            r_dst      <= bus.RegDst ? w_rd : w_rt;
            r_regwrite <= bus.RegWrite;
            r_memtoreg <= bus.MemtoReg;
            r_store    <= bus.MemWrite;
            r_zero     <= (w_alu_res == '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[r_dst] <= w_wr_data;
        end
    end
endmodule

// File: tb/tb_cpu_eu_pipe.sv
// tb/tb_cpu_eu_pipe.sv - directed vector bench for cpu_eu_pipe
module tb_cpu_eu_pipe;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct {
        ctrl_t       c;
        logic [25:0] ins;
        int          dst;
        logic [31:0] val;
        logic        z;
    } vec_t;

    localparam ctrl_t C_RTYPE  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
    localparam ctrl_t C_ADDI   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
    localparam ctrl_t C_SUBI   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
    localparam ctrl_t C_ORI    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11};
    localparam ctrl_t C_LW     = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00};
    localparam ctrl_t C_LW_ALU = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
    localparam ctrl_t C_SW     = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;
    vec_t vt[16];

    cpu_eu_pipe_if #(.DW(32)) bus ();

    cpu_eu_pipe #(.DW(32), .NREG(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [25:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [25:0] i_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [15:0] imm);
        return {rs, rt, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic put(input ctrl_t c, input logic [25:0] ins);
        bus.in_valid    = 1'b1;
        bus.RegDst      = c.reg_dst;
        bus.ALUSrc      = c.alu_src;
        bus.RegWrite    = c.reg_write;
        bus.MemtoReg    = c.mem_to_reg;
        bus.MemRead     = c.mem_read;
        bus.MemWrite    = c.mem_write;
        bus.ALUOp       = c.alu_op;
        bus.Instruction = ins;
        chk("in_ready before accept", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Observe a register by storing it and watching the memory port.
    task automatic rd_chk(input int r, input logic [31:0] exp, input string nm);
        put(C_SW, i_type(5'd0, 5'(r), 16'd8));
        bus.in_valid = 1'b0;
        chk($sformatf("%s sw req", nm), {31'd0, bus.ram_req}, 32'd1);
        chk($sformatf("%s sw we", nm), {31'd0, bus.ram_we}, 32'd1);
        chk($sformatf("%s sw addr", nm), bus.ram_addr, 32'd8);
        chk($sformatf("%s value", nm), bus.ram_wdata, exp);
        bus.ram_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.ram_ack = 1'b0;
        chk($sformatf("%s sw done busy", nm), {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        vt[0]  = '{C_RTYPE, r_type(5'd1, 5'd1, 5'd3, 6'h22), 3, 32'h0000_0000, 1'b1};
        vt[1]  = '{C_ADDI,  i_type(5'd0, 5'd5, 16'hFFFF), 5, 32'hFFFF_FFFF, 1'b0};
        vt[2]  = '{C_ADDI,  i_type(5'd0, 5'd6, 16'd1),    6, 32'h0000_0001, 1'b0};
        vt[3]  = '{C_RTYPE, r_type(5'd5, 5'd6, 5'd7, 6'h2A), 7, 32'h0000_0001, 1'b0};
        vt[4]  = '{C_RTYPE, r_type(5'd6, 5'd5, 5'd8, 6'h2A), 8, 32'h0000_0000, 1'b1};
        vt[5]  = '{C_RTYPE, r_type(5'd5, 5'd2, 5'd9, 6'h24), 9, 32'h0000_000A, 1'b0};
        vt[6]  = '{C_RTYPE, r_type(5'd1, 5'd2, 5'd10, 6'h25), 10, 32'h0000_000F, 1'b0};
        vt[7]  = '{C_RTYPE, r_type(5'd1, 5'd2, 5'd11, 6'h27), 11, 32'hFFFF_FFF0, 1'b0};
        vt[8]  = '{C_RTYPE, r_type(5'd1, 5'd1, 5'd0, 6'h20), 0, 32'h0000_0000, 1'b0};
        vt[9]  = '{C_SUBI,  i_type(5'd2, 5'd12, 16'd3),   12, 32'h0000_0007, 1'b0};
        vt[10] = '{C_ORI,   i_type(5'd1, 5'd13, 16'h0030), 13, 32'h0000_0035, 1'b0};
        vt[11] = '{C_RTYPE, r_type(5'd1, 5'd2, 5'd14, 6'h00), 14, 32'h0000_000F, 1'b0};
        vt[12] = '{C_RTYPE, r_type(5'd5, 5'd6, 5'd15, 6'h20), 15, 32'h0000_0000, 1'b1};
        vt[13] = '{C_RTYPE, r_type(5'd0, 5'd6, 5'd16, 6'h22), 16, 32'hFFFF_FFFF, 1'b0};
        vt[14] = '{C_ADDI,  i_type(5'd0, 5'd17, 16'h8000), 17, 32'hFFFF_8000, 1'b0};
        vt[15] = '{C_SUBI,  i_type(5'd1, 5'd18, 16'd5),   18, 32'h0000_0000, 1'b1};

        reset_n         = 1'b0;
        bus.in_valid    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.ALUSrc      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.ALUOp       = 2'b00;
        bus.Instruction = '0;
        bus.ram_rdata   = '0;
        bus.ram_ack     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        chk("reset ram_req", {31'd0, bus.ram_req}, 32'd0);
        chk("reset ram_we", {31'd0, bus.ram_we}, 32'd0);
        chk("reset zero", {31'd0, bus.zero}, 32'd0);
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset ram_addr", bus.ram_addr, 32'd0);
        chk("reset ram_wdata", bus.ram_wdata, 32'd0);
        chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);

        // addi r1,r0,5 ; add r2,r1,r1 back to back
        put(C_ADDI, i_type(5'd0, 5'd1, 16'd5));
        put(C_RTYPE, r_type(5'd1, 5'd1, 5'd2, 6'h20));
        chk("add r2 zero", {31'd0, bus.zero}, 32'd0);
        chk("add r2 busy", {31'd0, bus.busy}, 32'd1);
        rd_chk(1, 32'd5, "r1");
        rd_chk(2, 32'd10, "r2");
        rd_chk(2, 32'd10, "r2 after sw");

        for (int i = 0; i < 16; i++) begin
            put(vt[i].c, vt[i].ins);
            chk($sformatf("v%0d zero", i), {31'd0, bus.zero}, {31'd0, vt[i].z});
            rd_chk(vt[i].dst, vt[i].val, $sformatf("v%0d r%0d", i, vt[i].dst));
        end

        // Three-deep forwarding chain
        put(C_ADDI, i_type(5'd0, 5'd21, 16'd3));
        put(C_RTYPE, r_type(5'd21, 5'd21, 5'd21, 6'h20));
        put(C_RTYPE, r_type(5'd21, 5'd1, 5'd21, 6'h20));
        rd_chk(21, 32'd11, "fwd chain r21");

        // Write to r0 then an immediate reader of r0
        put(C_RTYPE, r_type(5'd1, 5'd1, 5'd0, 6'h20));
        put(C_RTYPE, r_type(5'd0, 5'd0, 5'd22, 6'h20));
        rd_chk(22, 32'd0, "r0 no fwd r22");

        // WB drains to EMPTY when idle
        put(C_ADDI, i_type(5'd0, 5'd20, 16'd7));
        chk("wb busy", {31'd0, bus.busy}, 32'd1);
        idle();
        chk("wb drained busy", {31'd0, bus.busy}, 32'd0);
        rd_chk(20, 32'd7, "r20");

        // Stray ack outside MEM
        bus.ram_rdata = 32'h1234_5678;
        bus.ram_ack   = 1'b1;
        idle();
        bus.ram_ack = 1'b0;
        chk("stray ack busy", {31'd0, bus.busy}, 32'd0);
        chk("stray ack req", {31'd0, bus.ram_req}, 32'd0);

        // lw r4,4(r0) acked three cycles late
        put(C_LW, i_type(5'd0, 5'd4, 16'd4));
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("lw wait%0d req", k), {31'd0, bus.ram_req}, 32'd1);
            chk($sformatf("lw wait%0d we", k), {31'd0, bus.ram_we}, 32'd0);
            chk($sformatf("lw wait%0d addr", k), bus.ram_addr, 32'd4);
            chk($sformatf("lw wait%0d in_ready", k), {31'd0, bus.in_ready}, 32'd0);
            if (k == 2) begin
                bus.ram_rdata = 32'hDEAD_BEEF;
                bus.ram_ack   = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.ram_ack = 1'b0;
        chk("lw done req", {31'd0, bus.ram_req}, 32'd0);
        chk("lw done busy", {31'd0, bus.busy}, 32'd0);
        chk("lw done in_ready", {31'd0, bus.in_ready}, 32'd1);
        rd_chk(4, 32'hDEAD_BEEF, "r4 load");

        // Load with MemtoReg=0 writes the address
        put(C_LW_ALU, i_type(5'd0, 5'd19, 16'd12));
        bus.in_valid  = 1'b0;
        bus.ram_rdata = 32'hAAAA_5555;
        bus.ram_ack   = 1'b1;
        @(posedge clk);
        #1;
        bus.ram_ack = 1'b0;
        rd_chk(19, 32'd12, "r19 alu load");

        // Reset during a MEM wait
        put(C_LW, i_type(5'd0, 5'd4, 16'd0));
        bus.in_valid = 1'b0;
        chk("pre-reset zero", {31'd0, bus.zero}, 32'd1);
        @(posedge clk);
        #1;
        chk("pre-reset req", {31'd0, bus.ram_req}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset req", {31'd0, bus.ram_req}, 32'd0);
        chk("async reset busy", {31'd0, bus.busy}, 32'd0);
        chk("async reset zero", {31'd0, bus.zero}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rd_chk(4, 32'd0, "r4 after reset");
        rd_chk(1, 32'd0, "r1 after reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
